// File: rtl/pipe_exc_ctrl.sv
// Pipeline sequencing controller: stage flush/stall, exception entry, ERET return
// and multi-cycle divide stalls. Every output is registered for the state being entered.
//
// state | meaning
// RUN   | normal issue; triggers evaluated by priority
// DIVW  | divider busy; IF/ID and ID/EX held, EX/MEM bubbled
// EXC   | one-cycle exception/interrupt entry (flush + redirect + CP0 write)
// RET   | one-cycle ERET return (flush + redirect to EPC)
module pipe_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_F000,
  parameter int unsigned DIV_CYCLES = 32,
  parameter logic [4:0]  CODE_INT   = 5'd0,
  parameter logic [4:0]  CODE_SYS   = 5'd8,
  parameter logic [4:0]  CODE_BP    = 5'd9,
  parameter logic [4:0]  CODE_RI    = 5'd10,
  parameter logic [4:0]  CODE_OV    = 5'd12,
  parameter logic [4:0]  CODE_DIV0  = 5'd13
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_rsvd,
  input  logic        wb_of,
  input  logic        wb_div0,
  input  logic        wb_syscall,
  input  logic        wb_break,
  input  logic        wb_eret,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_pcplus4,
  input  logic        int_req,
  input  logic        int_en,
  input  logic [31:0] cp0_epc,
  input  logic        ld_use_hazard,
  input  logic        div_req,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        div_go,
  output logic        div_abort,
  output logic        cp0_we,
  output logic [4:0]  cp0_code,
  output logic [31:0] cp0_epc_wr,
  output logic        eret_go
);

  localparam int unsigned CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CYCLES);

  typedef enum logic [1:0] {RUN, DIVW, EXC, RET} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sync_exc;
  logic [4:0]    sync_code;

  assign sync_exc = wb_rsvd | wb_of | wb_div0 | wb_syscall | wb_break;

  always_comb begin
    sync_code = CODE_BP;
    if (wb_rsvd)         sync_code = CODE_RI;
    else if (wb_of)      sync_code = CODE_OV;
    else if (wb_div0)    sync_code = CODE_DIV0;
    else if (wb_syscall) sync_code = CODE_SYS;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      cnt          <= '0;
      if_id_stall  <= 1'b0;
      id_ex_stall  <= 1'b0;
      if_id_flush  <= 1'b0;
      id_ex_flush  <= 1'b0;
      ex_mem_flush <= 1'b0;
      mem_wb_flush <= 1'b0;
      pc_redirect  <= 1'b0;
      pc_target    <= '0;
      div_go       <= 1'b0;
      div_abort    <= 1'b0;
      cp0_we       <= 1'b0;
      cp0_code     <= '0;
      cp0_epc_wr   <= '0;
      eret_go      <= 1'b0;
    end else begin
      // Pulse outputs default low; each branch raises what its entered state needs.
      if_id_stall  <= 1'b0;
      id_ex_stall  <= 1'b0;
      if_id_flush  <= 1'b0;
      id_ex_flush  <= 1'b0;
      ex_mem_flush <= 1'b0;
      mem_wb_flush <= 1'b0;
      pc_redirect  <= 1'b0;
      pc_target    <= '0;
      div_go       <= 1'b0;
      div_abort    <= 1'b0;
      cp0_we       <= 1'b0;
      cp0_code     <= '0;
      cp0_epc_wr   <= '0;
      eret_go      <= 1'b0;
      case (state)
        RUN, DIVW: begin
          if (sync_exc || wb_eret || (int_req && int_en)) begin
            cnt          <= '0;
            if_id_flush  <= 1'b1;
            id_ex_flush  <= 1'b1;
            ex_mem_flush <= 1'b1;
            mem_wb_flush <= 1'b1;
            pc_redirect  <= 1'b1;
            div_abort    <= (state == DIVW);
            if (sync_exc) begin
              state      <= EXC;
              pc_target  <= EXC_VECTOR;
              cp0_we     <= 1'b1;
              cp0_code   <= sync_code;
              cp0_epc_wr <= wb_pc;
            end else if (wb_eret) begin
              state     <= RET;
              pc_target <= cp0_epc;
              eret_go   <= 1'b1;
            end else begin
              state      <= EXC;
              pc_target  <= EXC_VECTOR;
              cp0_we     <= 1'b1;
              cp0_code   <= CODE_INT;
              cp0_epc_wr <= wb_pcplus4;
            end
          end else if (state == DIVW) begin
            if (cnt == DIV_LAST) begin
              state <= RUN;
              cnt   <= '0;
            end else begin
              cnt          <= cnt + CW'(1);
              if_id_stall  <= 1'b1;
              id_ex_stall  <= 1'b1;
              ex_mem_flush <= 1'b1;
            end
          end else if (div_req) begin
            state        <= DIVW;
            cnt          <= CW'(1);
            div_go       <= 1'b1;
            if_id_stall  <= 1'b1;
            id_ex_stall  <= 1'b1;
            ex_mem_flush <= 1'b1;
          end else if (ld_use_hazard) begin
            if_id_stall <= 1'b1;
            id_ex_flush <= 1'b1;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
